// File: rtl/alarm_pkg.sv
// Shared types and widths for the alarm scheduler: time field widths,
// per-slot configuration payload and the scheduler state encoding.
package alarm_pkg;

   localparam int unsigned HOUR_W = 5;
   localparam int unsigned MIN_W  = 6;
   localparam int unsigned DAY_W  = 3;
   localparam int unsigned N_DAYS = 7;

   // Minute counters (ring and snooze) and the per-event snooze counter
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned SNZ_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_SNOOZED = 2'd2
   } alarm_state_e;

   typedef struct packed {
      logic [HOUR_W-1:0] hour;
      logic [MIN_W-1:0]  min;
      logic [N_DAYS-1:0] days;
      logic              on;
   } alarm_cfg_t;

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: stored {hour, min, days, on} plus its match compare
// against the current wall-clock time on the minute tick.
module alarm_slot
   import alarm_pkg::*;
(
   input  logic              Clk,
   input  logic              Clr,
   input  logic              we,
   input  alarm_cfg_t        wr_cfg,
   input  logic              min_tick,
   input  logic [DAY_W-1:0]  cur_day,
   input  logic [HOUR_W-1:0] cur_hour,
   input  logic [MIN_W-1:0]  cur_min,
   output alarm_cfg_t        cfg,
   output logic              match_c
);

   logic day_hit;

   // Slot storage, cleared by Clr ahead of any write
   always_ff @(posedge Clk) begin
      if (Clr) begin
         cfg <= '0;
      end else if (we) begin
         cfg <= wr_cfg;
      end
   end

   // Day-mask lookup; an out-of-range day never matches
   always_comb begin
      day_hit = 1'b0;
      if (cur_day < DAY_W'(N_DAYS)) begin
         day_hit = cfg.days[cur_day];
      end
   end

   assign match_c = min_tick & cfg.on & day_hit &
                    (cfg.hour == cur_hour) & (cfg.min == cur_min);

endmodule

// File: rtl/alarm_scheduler.sv
// Alarm scheduler: N_ALARMS programmable slots, lowest-index match wins,
// ring / snooze / stop / mute handling with minute-based timeouts.
// Optional macro ALARM_AUTO_SNOOZE_EN: when defined, a ring timeout behaves
// like a Snooze press (same count limit); otherwise it returns to idle.
module alarm_scheduler
   import alarm_pkg::*;
#(
   parameter  int unsigned N_ALARMS    = 7,
   parameter  int unsigned SNOOZE_MIN  = 9,
   parameter  int unsigned RING_MIN    = 5,
   parameter  int unsigned MAX_SNOOZES = 3,
   localparam int unsigned IDX_W       = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
)(
   input  logic              Clk,
   input  logic              Clr,
   input  logic              min_tick,
   input  logic [DAY_W-1:0]  cur_day,
   input  logic [HOUR_W-1:0] cur_hour,
   input  logic [MIN_W-1:0]  cur_min,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [HOUR_W-1:0] wr_hour,
   input  logic [MIN_W-1:0]  wr_min,
   input  logic [N_DAYS-1:0] wr_days,
   input  logic              wr_on,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [HOUR_W-1:0] rd_hour,
   output logic [MIN_W-1:0]  rd_min,
   output logic [N_DAYS-1:0] rd_days,
   output logic              rd_on,
   input  logic              Snooze,
   input  logic              Stop,
   input  logic              Mute,
   output logic              Sound,
   output logic [IDX_W-1:0]  ring_idx,
   output logic              alarm_active,
   output logic              snoozing
);

   alarm_cfg_t          wr_cfg;
   alarm_cfg_t          rd_cfg;
   alarm_cfg_t          slot_cfg [N_ALARMS];
   logic [N_ALARMS-1:0] slot_match;

   logic                any_match;
   logic [IDX_W-1:0]    match_idx;

   alarm_state_e        state;
   logic [CNT_W-1:0]    ring_cnt;
   logic [CNT_W-1:0]    snz_tmr;
   logic [SNZ_W-1:0]    snz_cnt;
   logic                mute_latch;

   assign wr_cfg = '{hour: wr_hour, min: wr_min, days: wr_days, on: wr_on};

   for (genvar i = 0; i < N_ALARMS; i++) begin : g_slot
      alarm_slot u_slot (
         .Clk      (Clk),
         .Clr      (Clr),
         .we       (wr_en && (wr_idx == IDX_W'(i))),
         .wr_cfg   (wr_cfg),
         .min_tick (min_tick),
         .cur_day  (cur_day),
         .cur_hour (cur_hour),
         .cur_min  (cur_min),
         .cfg      (slot_cfg[i]),
         .match_c  (slot_match[i])
      );
   end

   // Lowest-index matching slot wins
   always_comb begin
      any_match = 1'b0;
      match_idx = '0;
      for (int i = N_ALARMS - 1; i >= 0; i--) begin
         if (slot_match[i]) begin
            any_match = 1'b1;
            match_idx = IDX_W'(i);
         end
      end
   end

   // Display readback; out-of-range index reads as an empty slot
   always_comb begin
      rd_cfg = '0;
      if (32'(rd_idx) < N_ALARMS) begin
         rd_cfg = slot_cfg[rd_idx];
      end
   end

   assign rd_hour = rd_cfg.hour;
   assign rd_min  = rd_cfg.min;
   assign rd_days = rd_cfg.days;
   assign rd_on   = rd_cfg.on;

   // Event FSM: idle / ringing / snoozed with minute counters and mute latch
   always_ff @(posedge Clk) begin
      if (Clr) begin
         state      <= ST_IDLE;
         ring_idx   <= '0;
         ring_cnt   <= '0;
         snz_tmr    <= '0;
         snz_cnt    <= '0;
         mute_latch <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               mute_latch <= 1'b0;
               if (any_match) begin
                  state    <= ST_RINGING;
                  ring_idx <= match_idx;
                  snz_cnt  <= '0;
                  ring_cnt <= CNT_W'(RING_MIN);
               end
            end

            ST_RINGING: begin
               if (Mute) begin
                  mute_latch <= ~mute_latch;
               end
               if (Stop) begin
                  state      <= ST_IDLE;
                  mute_latch <= 1'b0;
               end else if (Snooze) begin
                  if (snz_cnt < SNZ_W'(MAX_SNOOZES)) begin
                     state   <= ST_SNOOZED;
                     snz_cnt <= snz_cnt + SNZ_W'(1);
                     snz_tmr <= CNT_W'(SNOOZE_MIN);
                  end else begin
                     state      <= ST_IDLE;
                     mute_latch <= 1'b0;
                  end
               end else if (min_tick) begin
                  if (ring_cnt <= CNT_W'(1)) begin
                     ring_cnt <= '0;
`ifdef ALARM_AUTO_SNOOZE_EN
                     if (snz_cnt < SNZ_W'(MAX_SNOOZES)) begin
                        state   <= ST_SNOOZED;
                        snz_cnt <= snz_cnt + SNZ_W'(1);
                        snz_tmr <= CNT_W'(SNOOZE_MIN);
                     end else begin
                        state      <= ST_IDLE;
                        mute_latch <= 1'b0;
                     end
`else
                     state      <= ST_IDLE;
                     mute_latch <= 1'b0;
`endif
                  end else begin
                     ring_cnt <= ring_cnt - CNT_W'(1);
                  end
               end
            end

            ST_SNOOZED: begin
               if (Mute) begin
                  mute_latch <= ~mute_latch;
               end
               if (Stop) begin
                  state      <= ST_IDLE;
                  mute_latch <= 1'b0;
               end else if (min_tick) begin
                  if (snz_tmr <= CNT_W'(1)) begin
                     snz_tmr  <= '0;
                     state    <= ST_RINGING;
                     ring_cnt <= CNT_W'(RING_MIN);
                  end else begin
                     snz_tmr <= snz_tmr - CNT_W'(1);
                  end
               end
            end

            default: begin
               state      <= ST_IDLE;
               mute_latch <= 1'b0;
            end
         endcase
      end
   end

   // Status decoded straight from the state and mute registers
   assign Sound        = (state == ST_RINGING) & ~mute_latch;
   assign alarm_active = (state != ST_IDLE);
   assign snoozing     = (state == ST_SNOOZED);

endmodule
